// File: rtl/amplitude_ram_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// amplitude_ram_scheduler_pkg
//   Shared types for the amplitude RAM scheduler slice.
//   - DEFAULT_NUM_QUBIT / DEFAULT_COMPLEX_BIT : default geometry of the RAM
//   - amp_word_t   : one amplitude word, {real, imag}
//   - init_state_t : init sweep state (IDLE / INIT)
// ---------------------------------------------------------------------------
package amplitude_ram_scheduler_pkg;

  localparam int DEFAULT_NUM_QUBIT   = 4;
  localparam int DEFAULT_COMPLEX_BIT = 24;

  // Amplitude word layout: real part in the upper half, imaginary in the lower.
  typedef struct packed {
    logic [DEFAULT_COMPLEX_BIT-1:0] re;
    logic [DEFAULT_COMPLEX_BIT-1:0] im;
  } amp_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } init_state_t;

endpackage

// File: rtl/amplitude_ram_scheduler_rd_valid_pipe.sv
// ---------------------------------------------------------------------------
// rd_valid_pipe
//   DEPTH-deep valid shift register matching the RAM read latency, so that a
//   flag launched with a read request emerges together with its read data.
//   Ports:
//     clk       : clock
//     rst       : asynchronous active-high reset, clears all in-flight flags
//     in_valid  : flag entering the pipe
//     out_valid : flag leaving the pipe DEPTH cycles later
// ---------------------------------------------------------------------------
module rd_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] pipe;

  // A single-stage pipe cannot be sliced below bit 0, so it gets its own branch.
  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe <= '0;
        else     pipe <= in_valid;
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[DEPTH-2:0], in_valid};
      end
    end
  endgenerate

  assign out_valid = pipe[DEPTH-1];

endmodule

// File: rtl/amplitude_ram_scheduler.sv
// ---------------------------------------------------------------------------
// amplitude_ram_scheduler
//   Shares the single-read / single-write amplitude RAM between the cofactor
//   update path (top priority, never stalled), the init sweep engine (writes
//   the |0..0> state) and the host readout port (valid/ready).
//   Ports:
//     clk, rst                 : clock, asynchronous active-high reset
//     init_start               : pulse, start an init sweep (ignored while busy)
//     init_busy / init_done    : sweep running / pulse on the last sweep write
//     upd_error                : sticky, update traffic seen during a sweep
//     upd_rd_* / upd_wr_*      : update-path read and write requests
//     host_rd_req/addr/ready   : host read request handshake
//     host_rd_valid/data       : host read return
//     ram_rd_* / ram_wr_*      : amplitude RAM ports
// ---------------------------------------------------------------------------
module amplitude_ram_scheduler
  import amplitude_ram_scheduler_pkg::*;
#(
  parameter int num_qubit   = DEFAULT_NUM_QUBIT,
  parameter int complex_bit = DEFAULT_COMPLEX_BIT,
  parameter int RD_LAT      = 1,
  parameter logic [complex_bit-1:0] INIT_ONE =
    {{(complex_bit-1){1'b0}}, 1'b1} << (complex_bit - 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_start,
  output logic                     init_busy,
  output logic                     init_done,
  output logic                     upd_error,
  input  logic                     upd_rd_valid,
  input  logic [num_qubit-1:0]     upd_rd_addr,
  input  logic                     upd_wr_en,
  input  logic [num_qubit-1:0]     upd_wr_addr,
  input  logic [2*complex_bit-1:0] upd_wr_data,
  input  logic                     host_rd_req,
  input  logic [num_qubit-1:0]     host_rd_addr,
  output logic                     host_rd_ready,
  output logic                     host_rd_valid,
  output logic [2*complex_bit-1:0] host_rd_data,
  output logic                     ram_rd_en,
  output logic [num_qubit-1:0]     ram_rd_addr,
  input  logic [2*complex_bit-1:0] ram_rd_data,
  output logic                     ram_wr_en,
  output logic [num_qubit-1:0]     ram_wr_addr,
  output logic [2*complex_bit-1:0] ram_wr_data
);

  localparam logic [num_qubit-1:0]     LAST_ADDR = '1;
  localparam logic [num_qubit-1:0]     ONE_ADDR  = {{(num_qubit-1){1'b0}}, 1'b1};
  localparam logic [2*complex_bit-1:0] INIT_WORD = {INIT_ONE, {complex_bit{1'b0}}};

  init_state_t          state, next_state;
  logic [num_qubit-1:0] counter, next_counter;
  logic                 sweep_write;

  assign init_busy = (state == INIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
    end
  end

  // The sweep only owns the write port in cycles the update path leaves free;
  // a stalled cycle simply holds the counter and retries the same address.
  always_comb begin
    next_state   = state;
    next_counter = counter;
    sweep_write  = 1'b0;
    init_done    = 1'b0;
    case (state)
      IDLE: begin
        if (init_start) begin
          next_state   = INIT;
          next_counter = '0;
        end
      end
      INIT: begin
        if (!upd_wr_en) begin
          sweep_write  = 1'b1;
          next_counter = counter + ONE_ADDR;
          if (counter == LAST_ADDR) begin
            init_done  = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Update traffic during a sweep is still served but corrupts the sweep, so
  // it is flagged until software restarts the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_error <= 1'b0;
    end else if (state == IDLE && init_start) begin
      upd_error <= 1'b0;
    end else if (state == INIT && (upd_rd_valid || upd_wr_en)) begin
      upd_error <= 1'b1;
    end
  end

  // Read port: update path first, host only when neither update nor sweep is active.
  always_comb begin
    host_rd_ready = 1'b0;
    ram_rd_en     = 1'b0;
    ram_rd_addr   = '0;
    if (!rst) begin
      if (upd_rd_valid) begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = upd_rd_addr;
      end else if (host_rd_req && !init_busy) begin
        host_rd_ready = 1'b1;
        ram_rd_en     = 1'b1;
        ram_rd_addr   = host_rd_addr;
      end
    end
  end

  // Write port: update path first, then the init sweep.
  always_comb begin
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    if (!rst) begin
      if (upd_wr_en) begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = upd_wr_addr;
        ram_wr_data = upd_wr_data;
      end else if (sweep_write) begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = counter;
        ram_wr_data = (counter == '0) ? INIT_WORD : '0;
      end
    end
  end

  rd_valid_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (host_rd_ready),
    .out_valid (host_rd_valid)
  );

  assign host_rd_data = ram_rd_data;

endmodule

// File: tb/tb_amplitude_ram_scheduler.sv
// ---------------------------------------------------------------------------
// tb_amplitude_ram_scheduler
//   Directed bench for amplitude_ram_scheduler with a behavioural
//   1-cycle-latency RAM attached to the scheduler's RAM ports.
// ---------------------------------------------------------------------------
module tb_amplitude_ram_scheduler;
  import amplitude_ram_scheduler_pkg::*;

  localparam int NQ = 4;
  localparam int CB = 24;
  localparam int W  = 2 * CB;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_start;
  logic          init_busy;
  logic          init_done;
  logic          upd_error;
  logic          upd_rd_valid;
  logic [NQ-1:0] upd_rd_addr;
  logic          upd_wr_en;
  logic [NQ-1:0] upd_wr_addr;
  logic [W-1:0]  upd_wr_data;
  logic          host_rd_req;
  logic [NQ-1:0] host_rd_addr;
  logic          host_rd_ready;
  logic          host_rd_valid;
  logic [W-1:0]  host_rd_data;
  logic          ram_rd_en;
  logic [NQ-1:0] ram_rd_addr;
  logic [W-1:0]  ram_rd_data;
  logic          ram_wr_en;
  logic [NQ-1:0] ram_wr_addr;
  logic [W-1:0]  ram_wr_data;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [W-1:0] mem [16];
  logic [W-1:0] initWord;
  amp_word_t    initAmp;

  localparam logic [W-1:0] STALL_DATA = 48'h123456_654321;

  always #5 clk = ~clk;

  amplitude_ram_scheduler #(
    .num_qubit   (NQ),
    .complex_bit (CB),
    .RD_LAT      (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .init_start    (init_start),
    .init_busy     (init_busy),
    .init_done     (init_done),
    .upd_error     (upd_error),
    .upd_rd_valid  (upd_rd_valid),
    .upd_rd_addr   (upd_rd_addr),
    .upd_wr_en     (upd_wr_en),
    .upd_wr_addr   (upd_wr_addr),
    .upd_wr_data   (upd_wr_data),
    .host_rd_req   (host_rd_req),
    .host_rd_addr  (host_rd_addr),
    .host_rd_ready (host_rd_ready),
    .host_rd_valid (host_rd_valid),
    .host_rd_data  (host_rd_data),
    .ram_rd_en     (ram_rd_en),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_data   (ram_rd_data),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data)
  );

  // Behavioural RAM: one read and one write port, registered read data.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  function automatic logic [W-1:0] updWord(input logic [NQ-1:0] a);
    logic [CB-1:0] re;
    logic [CB-1:0] im;
    re = 24'hA00000 | {20'h0, a};
    im = 24'h0B0000 | {20'h0, a};
    return {re, im};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives a full input vector in the low clock phase, then settles 1 time unit.
  task automatic applyStimulus(input logic st, input logic urv, input logic [NQ-1:0] ura,
                               input logic uwe, input logic [NQ-1:0] uwa,
                               input logic [W-1:0] uwd, input logic hrq,
                               input logic [NQ-1:0] hra);
    @(negedge clk);
    init_start   = st;
    upd_rd_valid = urv;
    upd_rd_addr  = ura;
    upd_wr_en    = uwe;
    upd_wr_addr  = uwa;
    upd_wr_data  = uwd;
    host_rd_req  = hrq;
    host_rd_addr = hra;
    #1;
  endtask

  initial begin
    initAmp.re = 24'h400000;
    initAmp.im = '0;
    initWord   = initAmp;

    // Reset with update write and host request pending: everything gated off.
    rst          = 1'b1;
    init_start   = 1'b0;
    upd_rd_valid = 1'b0;
    upd_rd_addr  = '0;
    upd_wr_en    = 1'b1;
    upd_wr_addr  = 4'd2;
    upd_wr_data  = STALL_DATA;
    host_rd_req  = 1'b1;
    host_rd_addr = 4'd2;
    @(negedge clk);
    #1;
    checkOutput("rst_busy", init_busy, 0);
    checkOutput("rst_done", init_done, 0);
    checkOutput("rst_err", upd_error, 0);
    checkOutput("rst_hvalid", host_rd_valid, 0);
    checkOutput("rst_wr_en", ram_wr_en, 0);
    checkOutput("rst_rd_en", ram_rd_en, 0);
    checkOutput("rst_ready", host_rd_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Plain init sweep.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("init_start_wr_en", ram_wr_en, 0);
    checkOutput("init_start_busy", init_busy, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("init_wr_en", ram_wr_en, 1);
      checkOutput("init_wr_addr", ram_wr_addr, 64'(i));
      checkOutput("init_wr_data", ram_wr_data, (i == 0) ? 64'(initWord) : 64'd0);
      checkOutput("init_done", init_done, (i == 15) ? 64'd1 : 64'd0);
      checkOutput("init_busy", init_busy, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("init_end_busy", init_busy, 0);
    checkOutput("init_end_wr_en", ram_wr_en, 0);
    checkOutput("init_end_done", init_done, 0);

    // Sweep stalled by an update write at sweep cycle 5.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 17; c++) begin
      if (c == 5) begin
        applyStimulus(0, 0, 0, 1, 4'd9, STALL_DATA, 0, 0);
        checkOutput("stall_wr_addr", ram_wr_addr, 9);
        checkOutput("stall_wr_data", ram_wr_data, 64'(STALL_DATA));
        checkOutput("stall_done", init_done, 0);
        checkOutput("stall_err_pre", upd_error, 0);
      end else begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_sweep_addr", ram_wr_addr, (c < 5) ? 64'(c) : 64'(c - 1));
        checkOutput("stall_sweep_done", init_done, (c == 16) ? 64'd1 : 64'd0);
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall_end_busy", init_busy, 0);
    checkOutput("stall_err_sticky", upd_error, 1);

    // New sweep clears the error; host is held off for the whole sweep.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd3);
      if (i == 0) checkOutput("err_cleared", upd_error, 0);
      checkOutput("blk_ready", host_rd_ready, 0);
      checkOutput("blk_rd_en", ram_rd_en, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd3);
    checkOutput("blk_release_ready", host_rd_ready, 1);
    checkOutput("blk_release_addr", ram_rd_addr, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("blk_valid", host_rd_valid, 1);
    checkOutput("blk_data", host_rd_data, 0);

    // Fill a few addresses through the update path.
    for (int k = 0; k < 5; k++) begin
      logic [NQ-1:0] a;
      a = (k == 4) ? 4'd7 : 4'(k);
      applyStimulus(0, 0, 0, 1, a, updWord(a), 0, 0);
      checkOutput("fill_wr_data", ram_wr_data, 64'(updWord(a)));
    end
    checkOutput("fill_no_err", upd_error, 0);

    // Host vs update read arbitration.
    applyStimulus(0, 1, 4'd7, 0, 0, 0, 1, 4'd3);
    checkOutput("arb_rd_addr_upd", ram_rd_addr, 7);
    checkOutput("arb_ready_low", host_rd_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd3);
    checkOutput("arb_rd_addr_host", ram_rd_addr, 3);
    checkOutput("arb_ready_high", host_rd_ready, 1);
    checkOutput("arb_no_valid_upd", host_rd_valid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("arb_valid", host_rd_valid, 1);
    checkOutput("arb_data", host_rd_data, 64'(updWord(4'd3)));

    // Streaming host reads 0,1,2.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd0);
    checkOutput("strm_ready0", host_rd_ready, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd1);
    checkOutput("strm_valid0", host_rd_valid, 1);
    checkOutput("strm_data0", host_rd_data, 64'(updWord(4'd0)));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd2);
    checkOutput("strm_valid1", host_rd_valid, 1);
    checkOutput("strm_data1", host_rd_data, 64'(updWord(4'd1)));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("strm_valid2", host_rd_valid, 1);
    checkOutput("strm_data2", host_rd_data, 64'(updWord(4'd2)));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("strm_valid_end", host_rd_valid, 0);

    // Reset with one host read in flight drops it.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd1);
    checkOutput("flight_ready", host_rd_ready, 1);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    host_rd_req = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("flight_valid", host_rd_valid, 0);
    checkOutput("flight_rd_en", ram_rd_en, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Reset mid-sweep once the write of address 8 has been issued.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mid_wr_addr", ram_wr_addr, 64'(i));
    end
    @(posedge clk);
    #1;
    rst         = 1'b1;
    upd_wr_en   = 1'b1;
    host_rd_req = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("mid_rst_busy", init_busy, 0);
    checkOutput("mid_rst_done", init_done, 0);
    checkOutput("mid_rst_wr_en", ram_wr_en, 0);
    checkOutput("mid_rst_wr_addr", ram_wr_addr, 0);
    checkOutput("mid_rst_wr_data", ram_wr_data, 0);
    checkOutput("mid_rst_rd_en", ram_rd_en, 0);
    checkOutput("mid_rst_ready", host_rd_ready, 0);
    checkOutput("mid_rst_hvalid", host_rd_valid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_busy", init_busy, 0);
      checkOutput("post_rst_done", init_done, 0);
      checkOutput("post_rst_wr_en", ram_wr_en, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
